wb_bram_slave: RTL and testbench

Wishbone slave (responder) holding a single-port block RAM, designed to sit on one slave port of the conbus interconnect. It answers classic single reads and writes with one wait state. It also answers incrementing bursts (CTI 3'b010) with one ack per cycle after the first. It is the terminating end of the bus that the interconnect drives: it decodes nothing and responds to every strobe it receives.

---
 rtl/wb_bram_slave_if.sv | 32 +++
 rtl/wb_bram_slave.sv | 129 ++++++++++++
 tb/tb_wb_bram_slave.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bram_slave_if.sv
// rtl/wb_bram_slave_if.sv - Wishbone bus bundle between a conbus slave port and the BRAM responder
//
// Purpose: carries one Wishbone slave port. The master modport is the
// interconnect side and the slave modport is the responder side.
// Signals:
//   wb_adr_i  byte address            wb_dat_i  write data
//   wb_dat_o  read data               wb_sel_i  byte enables
//   wb_cti_i  cycle type identifier   wb_we_i   write enable
//   wb_cyc_i  bus cycle active        wb_stb_i  transfer strobe
//   wb_ack_o  transfer acknowledge

interface wb_bram_slave_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic [2:0]  wb_cti_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_bram_slave.sv
// rtl/wb_bram_slave.sv - Wishbone slave wrapping a single-port 32-bit block RAM
//
// Purpose: answers every strobe it sees. Classic transfers take one wait
// state; incrementing bursts (cti 3'b010) ack every cycle after the first.
// Optional feature macro: WB_BRAM_SLAVE_BURST_EN builds the BURST state and
// the internal address incrementer. Without it every transfer is classic.
// Ports:
//   sys_clk  system clock, rising edge
//   sys_rst  asynchronous active-low reset
//   wb       Wishbone slave modport (address, data, select, cti, we, cyc,
//            stb in; read data and ack out)
// Parameter:
//   adr_width  word-address width, RAM depth 2**adr_width words

module wb_bram_slave #(
    parameter int adr_width = 11
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    wb_bram_slave_if.slave   wb
);

`ifdef WB_BRAM_SLAVE_BURST_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, BURST = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;
`endif

    state_t                 state, state_nxt;
    logic [adr_width-1:0]   ba, ba_nxt;
    logic [adr_width-1:0]   rd_addr;
    logic                   rd_en;
    logic                   req;
    logic                   ack;
    logic                   wr_en;
    logic [adr_width-1:0]   adr_word;
    logic [31:0]            dat_q;
    logic [31:0]            mem [0:(2**adr_width)-1];

    assign req      = wb.wb_cyc_i & wb.wb_stb_i;
    assign adr_word = wb.wb_adr_i[adr_width+1:2];

    // Any non-idle state acks, but only while the master is still requesting.
    assign ack          = req & (state != IDLE);
    assign wr_en        = ack & wb.wb_we_i;
    assign wb.wb_ack_o  = ack;
    // Read data comes straight from the RAM output register, never from cyc/stb.
    assign wb.wb_dat_o  = dat_q;

    logic unused_adr;
    assign unused_adr = &{1'b0, wb.wb_adr_i[31:adr_width+2], wb.wb_adr_i[1:0]};
`ifndef WB_BRAM_SLAVE_BURST_EN
    logic unused_cti;
    assign unused_cti = &{1'b0, wb.wb_cti_i};
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= IDLE;
            ba    <= '0;
        end else begin
            state <= state_nxt;
            ba    <= ba_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ba_nxt    = ba;
        rd_en     = 1'b0;
        rd_addr   = ba;
        case (state)
            IDLE: begin
                if (req) begin
                    ba_nxt  = adr_word;
                    rd_en   = 1'b1;
                    rd_addr = adr_word;
`ifdef WB_BRAM_SLAVE_BURST_EN
                    state_nxt = (wb.wb_cti_i == 3'b010) ? BURST : ACK;
`else
                    state_nxt = ACK;
`endif
                end
            end
            // Unconditional return forces an idle cycle between classic transfers.
            ACK: state_nxt = IDLE;
`ifdef WB_BRAM_SLAVE_BURST_EN
            BURST: begin
                if (!wb.wb_cyc_i) begin
                    state_nxt = IDLE;
                end else if (req) begin
                    if (wb.wb_cti_i == 3'b111) begin
                        state_nxt = IDLE;
                    end else begin
                        // Prefetch the next word so the following beat acks at once;
                        // the counter wraps at the top of the RAM.
                        ba_nxt  = ba + 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = ba + 1'b1;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Registered read port; held whenever no new read is issued.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            dat_q <= '0;
        end else if (rd_en) begin
            dat_q <= mem[rd_addr];
        end
    end

    // Byte-masked write to the current transfer address. A read issued on the
    // same edge samples the pre-write contents.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wb.wb_sel_i[i]) begin
                    mem[ba][8*i +: 8] <= wb.wb_dat_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_bram_slave.sv
// tb/tb_wb_bram_slave.sv - directed self-checking bench for wb_bram_slave

module tb_wb_bram_slave;

    logic sys_clk;
    logic sys_rst;
    int   checks;
    int   errors;

    wb_bram_slave_if bus ();

    wb_bram_slave #(.adr_width(4)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wb      (bus.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] cti);
        bus.wb_cyc_i = cyc;
        bus.wb_stb_i = stb;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_cti_i = cti;
    endtask

    task automatic idle_bus;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    endtask

    // Classic transfer: ack low in the request cycle, high in the next one.
    task automatic classic(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input logic [31:0] exp_rd, input logic chk_rd);
        drive(1'b1, 1'b1, we, adr, dat, sel, 3'b000);
        @(negedge sys_clk);
        check({tag, "_ack_wait"}, {31'b0, bus.wb_ack_o}, 32'd0);
        nxt;
        @(negedge sys_clk);
        check({tag, "_ack"}, {31'b0, bus.wb_ack_o}, 32'd1);
        if (chk_rd) check({tag, "_rdata"}, bus.wb_dat_o, exp_rd);
        nxt;
        idle_bus();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sys_rst = 1'b0;
        idle_bus();
        @(negedge sys_clk);
        check("rst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check("rst_dat", bus.wb_dat_o, 32'd0);
        nxt;
        nxt;
        sys_rst = 1'b1;
        nxt;

        // Single write then read of byte address 0x10
        classic("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        classic("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1);
        @(negedge sys_clk);
        check("dat_hold", bus.wb_dat_o, 32'hDEADBEEF);
        nxt;

        // Byte-lane write on word 4
        classic("wr4a", 1'b1, 32'h10, 32'h11223344, 4'hF, 32'h0, 1'b0);
        classic("wr4b", 1'b1, 32'h10, 32'hAABBCCDD, 4'b0011, 32'h0, 1'b0);
        classic("rd4", 1'b0, 32'h10, 32'h0, 4'hF, 32'h1122CCDD, 1'b1);

        // Zero-select write leaves memory unchanged
        classic("wr5", 1'b1, 32'h14, 32'h55555555, 4'hF, 32'h0, 1'b0);
        classic("wr5z", 1'b1, 32'h14, 32'h00000000, 4'h0, 32'h0, 1'b0);
        classic("rd5", 1'b0, 32'h14, 32'h0, 4'h0, 32'h55555555, 1'b1);

        // Preload words 8..11 with their own index
        for (int w = 8; w < 12; w++) begin
            classic("pre", 1'b1, 32'(4 * w), 32'(w), 4'hF, 32'h0, 1'b0);
        end

`ifdef WB_BRAM_SLAVE_BURST_EN
        // 4-beat burst read from word 8; master address is garbage after the start
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b010);
        @(negedge sys_clk);
        check("br_ack_wait", {31'b0, bus.wb_ack_o}, 32'd0);
        for (int b = 0; b < 4; b++) begin
            nxt;
            bus.wb_adr_i = 32'h0;
            bus.wb_cti_i = (b == 3) ? 3'b111 : 3'b010;
            @(negedge sys_clk);
            check("br_ack", {31'b0, bus.wb_ack_o}, 32'd1);
            check("br_data", bus.wb_dat_o, 32'(8 + b));
        end
        nxt;
        bus.wb_cti_i = 3'b000;
        @(negedge sys_clk);
        check("br_after", {31'b0, bus.wb_ack_o}, 32'd0);
        nxt;
        idle_bus();
        nxt;

        // 3-beat burst write from word 15 wraps to words 0 and 1
        drive(1'b1, 1'b1, 1'b1, 32'h3C, 32'hA0, 4'hF, 3'b010);
        @(negedge sys_clk);
        check("bw_ack_wait", {31'b0, bus.wb_ack_o}, 32'd0);
        for (int b = 0; b < 3; b++) begin
            nxt;
            bus.wb_dat_i = 32'hA0 + 32'(b);
            bus.wb_cti_i = (b == 2) ? 3'b111 : 3'b010;
            @(negedge sys_clk);
            check("bw_ack", {31'b0, bus.wb_ack_o}, 32'd1);
        end
        nxt;
        idle_bus();
        classic("rd15", 1'b0, 32'h3C, 32'h0, 4'h0, 32'hA0, 1'b1);
        classic("rd0", 1'b0, 32'h00, 32'h0, 4'h0, 32'hA1, 1'b1);
        classic("rd1", 1'b0, 32'h04, 32'h0, 4'h0, 32'hA2, 1'b1);

        // Strobe gap of two cycles after beat 2
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b010);
        nxt;
        @(negedge sys_clk);
        check("gap_b1", bus.wb_dat_o, 32'd8);
        nxt;
        @(negedge sys_clk);
        check("gap_b2", bus.wb_dat_o, 32'd9);
        nxt;
        bus.wb_stb_i = 1'b0;
        @(negedge sys_clk);
        check("gap_ack1", {31'b0, bus.wb_ack_o}, 32'd0);
        nxt;
        @(negedge sys_clk);
        check("gap_ack2", {31'b0, bus.wb_ack_o}, 32'd0);
        nxt;
        bus.wb_stb_i = 1'b1;
        bus.wb_cti_i = 3'b111;
        @(negedge sys_clk);
        check("gap_b3_ack", {31'b0, bus.wb_ack_o}, 32'd1);
        check("gap_b3", bus.wb_dat_o, 32'd10);
        nxt;
        idle_bus();
        nxt;

        // cyc dropped mid-burst returns the FSM to IDLE
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b010);
        nxt;
        @(negedge sys_clk);
        check("abort_b1", bus.wb_dat_o, 32'd8);
        nxt;
        idle_bus();
        @(negedge sys_clk);
        check("abort_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        nxt;
        classic("abort_rd", 1'b0, 32'h24, 32'h0, 4'h0, 32'd9, 1'b1);

        // Reset pulse mid-burst
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b010);
        nxt;
        @(negedge sys_clk);
        check("rstm_b1", bus.wb_dat_o, 32'd8);
        nxt;
        sys_rst = 1'b0;
        #1;
        check("rstm_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check("rstm_dat", bus.wb_dat_o, 32'd0);
        nxt;
        idle_bus();
        sys_rst = 1'b1;
        nxt;
        classic("rstm_rd", 1'b0, 32'h28, 32'h0, 4'h0, 32'd10, 1'b1);
`else
        // Burst-tagged master advancing its own address: acks on alternate cycles
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b010);
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            check("alt_ack", {31'b0, bus.wb_ack_o}, 32'(k % 2));
            if (k % 2 == 1) check("alt_data", bus.wb_dat_o, 32'(8 + k / 2));
            nxt;
            if (k % 2 == 1) begin
                bus.wb_adr_i = 32'h20 + 32'(4 * (k / 2 + 1));
                bus.wb_cti_i = (k == 5) ? 3'b111 : 3'b010;
            end
        end
        idle_bus();
        nxt;

        // Reset pulse mid-transfer
        drive(1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 3'b000);
        nxt;
        @(negedge sys_clk);
        check("rstm_b1", bus.wb_dat_o, 32'd9);
        sys_rst = 1'b0;
        #1;
        check("rstm_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check("rstm_dat", bus.wb_dat_o, 32'd0);
        nxt;
        idle_bus();
        sys_rst = 1'b1;
        nxt;
        classic("rstm_rd", 1'b0, 32'h28, 32'h0, 4'h0, 32'd10, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
